// File: rtl/fdd_ctrl_pkg.sv
// Shared constants for the FDD drive controller: register map, status bit positions, hold states.
package fdd_ctrl_pkg;

  localparam logic [1:0] REG_HOLD  = 2'd0;
  localparam logic [1:0] REG_WPROT = 2'd1;
  localparam logic [1:0] REG_SIDE  = 2'd2;
  localparam logic [1:0] REG_DRIVE = 2'd3;

  localparam int DOUT_TIMEOUT = 7;
  localparam int DOUT_READY   = 6;
  localparam int DOUT_SIDE    = 5;
  localparam int DOUT_HOLD    = 4;
  localparam int DOUT_WPROT   = 3;

  typedef enum logic {IDLE, HOLD} hold_state_t;

endpackage

// File: rtl/fdd_drive_ctrl_slot.sv
// One image slot: remembers the size of the last completed download and whether it is usable.
module fdd_slot #(
  parameter int SIZE_W = 20
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              done,
  input  logic [SIZE_W-1:0] final_addr,
  output logic [SIZE_W-1:0] size,
  output logic              ready
);

  // A zero-length image is latched but never becomes ready.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      size  <= '0;
      ready <= 1'b0;
    end else if (done) begin
      size  <= final_addr;
      ready <= |final_addr;
    end else if (start) begin
      ready <= 1'b0;
    end
  end

endmodule

// File: rtl/fdd_drive_ctrl.sv
// Multi-drive FDD side/drive/hold controller. Define FDD_WRPROT_EN to add the per-drive
// write-protect mask register and the fdd_wprot output.
module fdd_drive_ctrl
  import fdd_ctrl_pkg::*;
#(
  parameter int NUM_DRIVES   = 4,
  parameter int SIZE_W       = 20,
  parameter int BASE_INDEX   = 2,
  parameter int HOLD_TIMEOUT = 4800000,
  localparam int DRV_W       = $clog2(NUM_DRIVES)
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic [4:0]              ioctl_index,
  input  logic [24:0]             ioctl_addr,
  input  logic                    wr,
  input  logic [1:0]              addr,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  input  logic                    fdd_drq,
  input  logic                    fdd_busy,
  output logic                    cpu_hold,
  output logic                    fdd_side,
  output logic [DRV_W-1:0]        fdd_drive,
  output logic                    fdd_ready,
  output logic [SIZE_W-1:0]       fdd_size,
  output logic [SIZE_W+DRV_W-1:0] fdd_base
`ifdef FDD_WRPROT_EN
  ,
  output logic                    fdd_wprot
`endif
);

  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  logic              wr_d, dl_d;
  logic              wr_rise, arm, fdd_rel;
  logic              dl_rise, dl_fall, slot_hit, dl_release;
  logic [5:0]        idx_rel;
  logic [DRV_W-1:0]  slot_sel;
  hold_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [NUM_DRIVES-1:0] ready_vec;
  logic [SIZE_W-1:0] size_arr [NUM_DRIVES];
  logic              unused_addr_bits;

  assign wr_rise = wr & ~wr_d;
  assign arm     = wr_rise && (addr == REG_HOLD);
  assign fdd_rel = fdd_drq | ~fdd_busy;
  assign dl_rise = ioctl_download & ~dl_d;
  assign dl_fall = ~ioctl_download & dl_d;

  // Indices below BASE_INDEX wrap to large values and fall outside the slot range.
  assign idx_rel    = {1'b0, ioctl_index} - 6'(BASE_INDEX);
  assign slot_hit   = idx_rel < 6'(NUM_DRIVES);
  assign slot_sel   = idx_rel[DRV_W-1:0];
  assign dl_release = dl_rise && slot_hit && (slot_sel == fdd_drive);
  assign unused_addr_bits = ^ioctl_addr[24:SIZE_W];

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_slot
    fdd_slot #(.SIZE_W(SIZE_W)) u_slot (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .start      (dl_rise && slot_hit && (slot_sel == DRV_W'(i))),
      .done       (dl_fall && slot_hit && (slot_sel == DRV_W'(i))),
      .final_addr (ioctl_addr[SIZE_W-1:0]),
      .size       (size_arr[i]),
      .ready      (ready_vec[i])
    );
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_d      <= 1'b0;
      dl_d      <= 1'b0;
      fdd_side  <= 1'b0;
      fdd_drive <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wr_d      <= wr;
      dl_d      <= ioctl_download;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (wr_rise && addr == REG_SIDE)
        fdd_side <= din[0];
      if (wr_rise && addr == REG_DRIVE && din < 8'(NUM_DRIVES))
        fdd_drive <= din[DRV_W-1:0];
    end
  end

  // Any release source beats a simultaneous arm; the counter only runs while holding.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (arm) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
    case (state_q)
      IDLE: if (arm && !fdd_rel) state_d = HOLD;
      HOLD: begin
        if (fdd_rel || dl_release) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!arm) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FDD_WRPROT_EN
  logic [NUM_DRIVES-1:0] wprot_mask;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wprot_mask <= '1;
    end else begin
      if (wr_rise && addr == REG_WPROT)
        wprot_mask <= din[NUM_DRIVES-1:0];
      if (dl_fall && slot_hit)
        wprot_mask[slot_sel] <= 1'b0;
    end
  end

  assign fdd_wprot = wprot_mask[fdd_drive];
`endif

  assign cpu_hold  = (state_q == HOLD);
  assign fdd_ready = ready_vec[fdd_drive];
  assign fdd_size  = size_arr[fdd_drive];
  assign fdd_base  = {fdd_drive, {SIZE_W{1'b0}}};

  always_comb begin
    dout               = '0;
    dout[DOUT_TIMEOUT] = timeout_q;
    dout[DOUT_READY]   = fdd_ready;
    dout[DOUT_SIDE]    = fdd_side;
    dout[DOUT_HOLD]    = cpu_hold;
`ifdef FDD_WRPROT_EN
    dout[DOUT_WPROT]   = fdd_wprot;
`endif
    dout[2:0]          = 3'(fdd_drive);
  end

endmodule

// File: tb/tb_fdd_drive_ctrl.sv
// Self-checking bench for fdd_drive_ctrl against a behavioural model of drives, hold and status.
module tb_fdd_drive_ctrl;

  localparam int ND = 4;
  localparam int SW = 20;
  localparam int BI = 2;
  localparam int HT = 100;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [4:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic        wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        fdd_drq = 1'b0;
  logic        fdd_busy = 1'b0;
  logic        cpu_hold, fdd_side, fdd_ready;
  logic [1:0]  fdd_drive;
  logic [SW-1:0]   fdd_size;
  logic [SW+1:0]   fdd_base;
`ifdef FDD_WRPROT_EN
  logic        fdd_wprot;
`endif

  int tests = 0;
  int fails = 0;

  int unsigned m_size [ND];
  bit          m_ready [ND];
  int          m_drive;
  bit          m_side, m_hold, m_timeout;

  always #5 clk_sys = ~clk_sys;

  fdd_drive_ctrl #(.NUM_DRIVES(ND), .SIZE_W(SW), .BASE_INDEX(BI), .HOLD_TIMEOUT(HT)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .wr(wr), .addr(addr), .din(din),
    .dout(dout), .fdd_drq(fdd_drq), .fdd_busy(fdd_busy), .cpu_hold(cpu_hold),
    .fdd_side(fdd_side), .fdd_drive(fdd_drive), .fdd_ready(fdd_ready),
    .fdd_size(fdd_size), .fdd_base(fdd_base)
`ifdef FDD_WRPROT_EN
    , .fdd_wprot(fdd_wprot)
`endif
  );

  function automatic logic [7:0] exp_dout();
    return {m_timeout, m_ready[m_drive], m_side, m_hold, 1'b0, 3'(m_drive)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_size[i]  = 0;
      m_ready[i] = 0;
    end
    m_drive = 0; m_side = 0; m_hold = 0; m_timeout = 0;
  endtask

  // One write pulse with wr held for len cycles; only the first cycle may act.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int len);
    @(negedge clk_sys);
    addr = a; din = d; wr = 1'b1;
    repeat (len) @(negedge clk_sys);
    wr = 1'b0;
    case (a)
      2'd0: begin
        m_timeout = 0;
        if (fdd_busy && !fdd_drq) m_hold = 1;
      end
      2'd2: m_side = d[0];
      2'd3: if (d < ND) m_drive = d;
      default: ;
    endcase
  endtask

  task automatic dl_start(input int idx);
    @(negedge clk_sys);
    ioctl_index = 5'(idx); ioctl_addr = '0; ioctl_download = 1'b1;
    if (idx >= BI && idx < BI + ND) begin
      m_ready[idx-BI] = 0;
      if (idx - BI == m_drive) m_hold = 0;
    end
  endtask

  task automatic dl_end(input int unsigned final_addr);
    int idx;
    idx = int'(ioctl_index);
    @(negedge clk_sys);
    ioctl_addr = 25'(final_addr);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    if (idx >= BI && idx < BI + ND) begin
      m_size[idx-BI]  = final_addr % (1 << SW);
      m_ready[idx-BI] = (m_size[idx-BI] != 0);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    tests++; if (dout !== 8'h00) begin fails++; $display("[TB] FAIL reset_dout: got %h want 00", dout); end
    tests++; if (cpu_hold !== 1'b0 || fdd_side !== 1'b0 || fdd_drive !== 2'd0) begin
      fails++; $display("[TB] FAIL reset_regs: hold=%b side=%b drive=%0d want 0 0 0", cpu_hold, fdd_side, fdd_drive); end
    tests++; if (fdd_ready !== 1'b0 || fdd_size !== '0 || fdd_base !== '0) begin
      fails++; $display("[TB] FAIL reset_slot: ready=%b size=%h base=%h want 0", fdd_ready, fdd_size, fdd_base); end
  endtask

  task automatic test_download_select();
    dl_start(3);
    repeat (4) @(negedge clk_sys) ioctl_addr = ioctl_addr + 25'd1;
    dl_end(32'h0C800);
    cpu_write(2'd3, 8'd1, 1);
    tests++; if (fdd_drive !== 2'd1) begin fails++; $display("[TB] FAIL sel_drive: got %0d want 1", fdd_drive); end
    tests++; if (fdd_size !== 20'h0C800) begin fails++; $display("[TB] FAIL sel_size: got %h want 0c800", fdd_size); end
    tests++; if (fdd_ready !== 1'b1) begin fails++; $display("[TB] FAIL sel_ready: got %b want 1", fdd_ready); end
    tests++; if (fdd_base !== 22'h100000) begin fails++; $display("[TB] FAIL sel_base: got %h want 100000", fdd_base); end
  endtask

  task automatic test_drive_range();
    cpu_write(2'd3, 8'd5, 1);
    tests++; if (fdd_drive !== 2'd1 || dout[2:0] !== 3'd1) begin
      fails++; $display("[TB] FAIL drive_oob1: drive=%0d dout=%0d want 1", fdd_drive, dout[2:0]); end
    cpu_write(2'd3, 8'd0, 1);
    cpu_write(2'd3, 8'd5, 1);
    tests++; if (fdd_drive !== 2'd0) begin fails++; $display("[TB] FAIL drive_oob0: got %0d want 0", fdd_drive); end
    tests++; if (dout !== exp_dout()) begin fails++; $display("[TB] FAIL drive_dout: got %h want %h", dout, exp_dout()); end
  endtask

  task automatic test_hold_drq();
    fdd_busy = 1'b1;
    cpu_write(2'd0, 8'd0, 1);
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("[TB] FAIL hold_arm: got %b want 1", cpu_hold); end
    repeat (9) @(negedge clk_sys);
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("[TB] FAIL hold_keep: got %b want 1", cpu_hold); end
    fdd_drq = 1'b1;
    @(negedge clk_sys);
    m_hold = 0;
    fdd_drq = 1'b0;
    tests++; if (cpu_hold !== 1'b0 || dout[7] !== 1'b0) begin
      fails++; $display("[TB] FAIL hold_drq_rel: hold=%b timeout=%b want 0 0", cpu_hold, dout[7]); end
  endtask

  task automatic test_timeout();
    int n;
    fdd_busy = 1'b1;
    cpu_write(2'd0, 8'd0, 5);
    n = 0;
    while (cpu_hold === 1'b1 && n < 3 * HT) begin
      n++;
      @(negedge clk_sys);
    end
    m_hold = 0; m_timeout = 1;
    tests++; if (n + 4 != HT) begin fails++; $display("[TB] FAIL timeout_len: got %0d cycles want %0d", n + 4, HT); end
    tests++; if (dout !== exp_dout()) begin fails++; $display("[TB] FAIL timeout_dout: got %h want %h", dout, exp_dout()); end
    cpu_write(2'd0, 8'd0, 1);
    tests++; if (dout[7] !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++; $display("[TB] FAIL timeout_clear: timeout=%b hold=%b want 0 1", dout[7], cpu_hold); end
    fdd_busy = 1'b0;
    @(negedge clk_sys);
    m_hold = 0;
    cpu_write(2'd0, 8'd0, 1);
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("[TB] FAIL hold_not_busy: got %b want 0", cpu_hold); end
  endtask

  task automatic test_dl_release();
    dl_start(2);
    dl_end(32'h2000);
    cpu_write(2'd3, 8'd0, 1);
    fdd_busy = 1'b1;
    cpu_write(2'd0, 8'd0, 1);
    tests++; if (cpu_hold !== 1'b1 || fdd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL dlrel_setup: hold=%b ready=%b want 1 1", cpu_hold, fdd_ready); end
    dl_start(2);
    @(negedge clk_sys);
    tests++; if (fdd_ready !== 1'b0 || cpu_hold !== 1'b0 || dout[7] !== 1'b0) begin
      fails++; $display("[TB] FAIL dlrel_start: ready=%b hold=%b timeout=%b want 0 0 0", fdd_ready, cpu_hold, dout[7]); end
    dl_end(0);
    tests++; if (fdd_ready !== 1'b0 || fdd_size !== '0) begin
      fails++; $display("[TB] FAIL dlrel_zero: ready=%b size=%h want 0 0", fdd_ready, fdd_size); end
    fdd_busy = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_random();
    int op, idx;
    int unsigned fa;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        idx = $urandom_range(0, 8);
        fa = $urandom_range(0, (1 << 21) - 1);
        if ($urandom_range(0, 4) == 0) fa = ($urandom_range(0, 1) == 0) ? 0 : (1 << SW);
        dl_start(idx);
        repeat (3) @(negedge clk_sys) ioctl_addr = ioctl_addr + 25'd1;
        dl_end(fa);
      end else if (op == 1) begin
        cpu_write(2'd3, 8'($urandom_range(0, 7)), 1);
      end else begin
        cpu_write(2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 1);
      end
      tests++; if (fdd_size !== SW'(m_size[m_drive])) begin
        fails++; $display("[TB] FAIL rnd_size it%0d: got %h want %h", it, fdd_size, m_size[m_drive]); end
      tests++; if (fdd_ready !== m_ready[m_drive]) begin
        fails++; $display("[TB] FAIL rnd_ready it%0d: got %b want %b", it, fdd_ready, m_ready[m_drive]); end
      tests++; if (fdd_base !== 22'(m_drive << SW)) begin
        fails++; $display("[TB] FAIL rnd_base it%0d: got %h want %h", it, fdd_base, 22'(m_drive << SW)); end
      tests++; if (dout !== exp_dout()) begin
        fails++; $display("[TB] FAIL rnd_dout it%0d: got %h want %h", it, dout, exp_dout()); end
    end
  endtask

  task automatic test_async_reset();
    fdd_busy = 1'b1;
    cpu_write(2'd2, 8'd1, 1);
    cpu_write(2'd3, 8'd2, 1);
    cpu_write(2'd0, 8'd0, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    tests++; if (cpu_hold !== 1'b0 || fdd_side !== 1'b0 || fdd_drive !== 2'd0 || fdd_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL async_reset: hold=%b side=%b drive=%0d ready=%b want 0", cpu_hold, fdd_side, fdd_drive, fdd_ready); end
    tests++; if (dout !== 8'h00) begin fails++; $display("[TB] FAIL async_dout: got %h want 00", dout); end
    @(negedge clk_sys);
    reset = 1'b0;
    fdd_busy = 1'b0;
    for (int d = 0; d < ND; d++) begin
      cpu_write(2'd3, 8'(d), 1);
      tests++; if (fdd_ready !== 1'b0 || fdd_size !== '0) begin
        fails++; $display("[TB] FAIL async_slot%0d: ready=%b size=%h want 0 0", d, fdd_ready, fdd_size); end
    end
    dl_start(4);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    dl_end(32'h1234);
    cpu_write(2'd3, 8'd2, 1);
    tests++; if (fdd_size !== 20'h01234 || fdd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_middl: size=%h ready=%b want 01234 1", fdd_size, fdd_ready); end
  endtask

  initial begin
    test_reset();
    test_download_select();
    test_drive_range();
    test_hold_drq();
    test_timeout();
    test_dl_release();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdd_drive_ctrl.md
Name: fdd_drive_ctrl

Overview:
- Parametrised successor to the single-drive FDD side/drive/hold register logic.
- Supports NUM_DRIVES image slots, each loaded through the ARM ioctl download path. Per-drive size and ready state are latched at the end of each download.
- Multiplexes the selected drive's size, ready flag and buffer base to the wd1793.
- Owns the CPU hold handshake, with a timeout the previous generation lacked.

Parameters:
- NUM_DRIVES, 4, number of image slots (2..8).
- SIZE_W, 20, width of image size / buffer offset.
- BASE_INDEX, 2, ioctl_index of drive 0; drive i uses BASE_INDEX+i.
- HOLD_TIMEOUT, 4800000, clk_sys cycles before a forced hold release.

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset  in  1  asynchronous active-high reset.
- ioctl_download  in  1  ARM download in progress.
- ioctl_index  in  5  download target index.
- ioctl_addr  in  25  download byte address; final value equals image size.
- wr  in  1  CPU write level (~cpu_wr_n & register select).
- addr  in  2  register address.
- din  in  8  CPU write data.
- dout  out  8  status readback, combinational.
- fdd_drq  in  1  wd1793 data request.
- fdd_busy  in  1  wd1793 busy.
- cpu_hold  out  1  CPU hold request.
- fdd_side  out  1  selected side.
- fdd_drive  out  $clog2(NUM_DRIVES)  selected drive.
- fdd_ready  out  1  ready flag of the selected drive.
- fdd_size  out  SIZE_W  image size of the selected drive.
- fdd_base  out  SIZE_W+$clog2(NUM_DRIVES)  buffer base = fdd_drive << SIZE_W.

Behaviour:
- Reset values: cpu_hold=0, fdd_side=0, fdd_drive=0, all ready=0, all sizes=0, timeout flag=0, hold counter=0. dout reflects these values.
- Write decode on the rising edge of wr, using a registered wr_d. Exactly one action per write pulse, taken the cycle after wr rises.
  - addr0: arm hold (cpu_hold<=1), clear counter and timeout flag.
  - addr1: reserved (see Optional Feature).
  - addr2: fdd_side<=din[0].
  - addr3: fdd_drive<=din[DRV_W-1:0] if value < NUM_DRIVES; otherwise ignored, drive unchanged.
- Hold state machine: states IDLE and HOLD.
  - IDLE->HOLD on an addr0 write.
  - HOLD->IDLE when fdd_drq | ~fdd_busy.
  - HOLD->IDLE when the counter reaches HOLD_TIMEOUT-1; this also sets the sticky timeout flag.
  - Counter increments only in HOLD.
  - Release dominates: an addr0 write in a cycle where ~fdd_busy leaves cpu_hold=0.
- Download tracking: falling edge of ioctl_download, one-cycle pipelined.
  - Applies when ioctl_index is in BASE_INDEX..BASE_INDEX+NUM_DRIVES-1, for slot i = index-BASE_INDEX.
  - size[i]<=ioctl_addr[SIZE_W-1:0].
  - ready[i]<=(ioctl_addr[SIZE_W-1:0]!=0); a zero-length image stays not-ready.
  - Addresses >= 2^SIZE_W are truncated silently.
- Rising edge of ioctl_download for slot i: ready[i]<=0 immediately. If i==fdd_drive and cpu_hold=1, the hold is released (no timeout flag).
- Indices outside the slot range are ignored entirely.
- Outputs fdd_ready, fdd_size and fdd_base follow fdd_drive combinationally from registered state.
- dout = {timeout, ready[selected], side, cpu_hold, 1'b0, drive zero-extended to 3 bits}. ready mask is not exported.
- Reset mid-download: slots are cleared, and the subsequent falling edge still latches normally.

Optional Feature:
- Macro: FDD_WRPROT_EN.
- With the macro defined:
  - addr1 write loads a per-drive write-protect mask from din[NUM_DRIVES-1:0].
  - Extra output fdd_wprot (1 bit) equals mask[fdd_drive]; dout[3] = fdd_wprot.
  - Mask resets to all ones.
  - A completed download clears that slot's mask bit.
- Without the macro: addr1 writes are ignored, fdd_wprot is absent, dout[3]=0.

Decomposition:
- Package fdd_ctrl_pkg holds:
  - register address constants REG_HOLD=0, REG_WPROT=1, REG_SIDE=2, REG_DRIVE=3;
  - dout bit-position constants;
  - hold state enum typedef {IDLE, HOLD}.
- One sub-module, fdd_slot, instantiated NUM_DRIVES times. It holds size/ready for one drive and takes start/end strobes plus the final address.

Test Plan:
- Download index 3, final ioctl_addr=0x0C800, then write addr3=1 -> fdd_drive=1, fdd_size=0x0C800, fdd_ready=1, fdd_base=0x100000.
- Write addr3=5 with NUM_DRIVES=4 -> fdd_drive unchanged (1); dout[2:0]=1.
- fdd_busy=1, write addr0, raise fdd_drq 10 cycles later -> cpu_hold high the cycle after wr rises, low one cycle after drq; timeout bit 0.
- fdd_busy=1 held, HOLD_TIMEOUT=100 override, write addr0 -> cpu_hold drops after exactly 100 cycles; dout[7]=1. Next addr0 write clears dout[7].
- Drive 0 selected and holding; start download index 2 -> fdd_ready=0 and cpu_hold=0 next cycle. End download with ioctl_addr=0 -> ready stays 0.
- Assert reset mid-hold with side=1 -> cpu_hold, fdd_side, fdd_drive and all ready flags are 0 immediately (asynchronous).
